// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 streaming convolution stage.
package conv_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_GAUSS  = 2'd1,
    MODE_SOBEL  = 2'd2,
    MODE_THRESH = 2'd3
  } conv_mode_t;

  localparam int GAUSS_SHIFT = 4;
  localparam int CONV_LAT    = 2;

endpackage

// File: rtl/line_buffer.sv
// One video line of storage: simple dual-port RAM, registered read, read-before-write.
module line_buffer #(
  parameter  int DEPTH = 640,
  parameter  int WIDTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Only the output register is reset; array contents stay stale on purpose.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/conv3x3_filter.sv
// 3x3 streaming convolution: passthrough, Gaussian blur, Sobel magnitude, Sobel threshold.
// Stage 1 builds the window from the line buffers; stage 2 applies the kernel.
module conv3x3_filter
  import conv_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] thresh,
  input  logic             in_ready,
  input  logic [PIX_W-1:0] pixel_in,
  output logic             out_ready,
  output logic [PIX_W-1:0] pixel_out
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int SW = PIX_W + 4;
  localparam int GW = PIX_W + 3;

  logic [CW-1:0]       r_col;
  logic [CW-1:0]       r_prev_col;
  logic [RW-1:0]       r_row;
  logic [CONV_LAT-1:0] r_vld;
  logic                r_border;
  conv_mode_t          r_mode;
  logic [PIX_W-1:0]    r_thresh;
  logic [PIX_W-1:0]    r_pix;
  logic [PIX_W-1:0]    r_win [3][2];
  logic [PIX_W-1:0]    r_pixel_out;

  logic [PIX_W-1:0] w_lb0_rd;
  logic [PIX_W-1:0] w_lb1_rd;
  logic [PIX_W-1:0] w_col [3];
  logic [PIX_W-1:0] w_win [3][3];
  logic             w_last_col;
  logic             w_last_row;
  logic             w_sof;

  assign w_last_col = (r_col == CW'(IMG_W - 1));
  assign w_last_row = (r_row == RW'(IMG_H - 1));
  assign w_sof      = (r_col == '0) && (r_row == '0);

  // The newest window column is the line-buffer read registers plus the last pixel.
  assign w_col[0] = w_lb1_rd;
  assign w_col[1] = w_lb0_rd;
  assign w_col[2] = r_pix;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
      for (genvar gj = 0; gj < 2; gj++) begin : g_win_col
        assign w_win[gi][gj] = r_win[gi][gj];
      end
      assign w_win[gi][2] = w_col[gi];
    end
  endgenerate

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk       (clk),
    .rst       (rst),
    .i_rd_en   (in_ready),
    .i_rd_addr (r_col),
    .o_rd_data (w_lb0_rd),
    .i_wr_en   (in_ready),
    .i_wr_addr (r_col),
    .i_wr_data (pixel_in)
  );

  // Second line is fed from the first one's registered read, so its write trails by one beat.
  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk       (clk),
    .rst       (rst),
    .i_rd_en   (in_ready),
    .i_rd_addr (r_col),
    .o_rd_data (w_lb1_rd),
    .i_wr_en   (in_ready),
    .i_wr_addr (r_prev_col),
    .i_wr_data (w_lb0_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_prev_col <= '0;
      r_vld      <= '0;
      r_border   <= 1'b1;
      r_mode     <= MODE_PASS;
      r_thresh   <= '0;
      r_pix      <= '0;
      for (int i = 0; i < 3; i++) begin
        r_win[i][0] <= '0;
        r_win[i][1] <= '0;
      end
    end else begin
      r_vld <= {r_vld[CONV_LAT-2:0], in_ready};
      if (in_ready) begin
        r_prev_col <= r_col;
        r_pix      <= pixel_in;
        r_border   <= (r_row < RW'(2)) || (r_col < CW'(2));
        for (int i = 0; i < 3; i++) begin
          r_win[i][0] <= r_win[i][1];
          r_win[i][1] <= w_col[i];
        end
        if (w_sof) begin
          r_mode   <= conv_mode_t'(mode);
          r_thresh <= thresh;
        end
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  logic [SW-1:0]    w_gsum;
  logic [GW-1:0]    w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
  logic [GW-1:0]    w_gx, w_gy, w_ax, w_ay;
  logic [GW:0]      w_mag;
  logic [PIX_W-1:0] w_mag_sat;
  logic [PIX_W-1:0] w_result;

  always_comb begin
    w_gsum = SW'(w_win[0][0]) + (SW'(w_win[0][1]) << 1) + SW'(w_win[0][2])
           + (SW'(w_win[1][0]) << 1) + (SW'(w_win[1][1]) << 2) + (SW'(w_win[1][2]) << 1)
           + SW'(w_win[2][0]) + (SW'(w_win[2][1]) << 1) + SW'(w_win[2][2]);

    w_gx_pos = GW'(w_win[0][2]) + (GW'(w_win[1][2]) << 1) + GW'(w_win[2][2]);
    w_gx_neg = GW'(w_win[0][0]) + (GW'(w_win[1][0]) << 1) + GW'(w_win[2][0]);
    w_gy_pos = GW'(w_win[2][0]) + (GW'(w_win[2][1]) << 1) + GW'(w_win[2][2]);
    w_gy_neg = GW'(w_win[0][0]) + (GW'(w_win[0][1]) << 1) + GW'(w_win[0][2]);

    // Two's-complement differences; the MSB is the sign.
    w_gx = w_gx_pos - w_gx_neg;
    w_gy = w_gy_pos - w_gy_neg;
    w_ax = w_gx[GW-1] ? (GW'(0) - w_gx) : w_gx;
    w_ay = w_gy[GW-1] ? (GW'(0) - w_gy) : w_gy;

    w_mag     = {1'b0, w_ax} + {1'b0, w_ay};
    w_mag_sat = (|w_mag[GW:PIX_W]) ? '1 : w_mag[PIX_W-1:0];

    w_result = '0;
    case (r_mode)
      MODE_PASS:   w_result = w_win[1][1];
      MODE_GAUSS:  w_result = PIX_W'(w_gsum >> GAUSS_SHIFT);
      MODE_SOBEL:  w_result = w_mag_sat;
      MODE_THRESH: w_result = (w_mag_sat >= r_thresh) ? '1 : '0;
      default:     w_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pixel_out <= '0;
    end else if (r_vld[0]) begin
      r_pixel_out <= r_border ? '0 : w_result;
    end
  end

  assign out_ready = r_vld[CONV_LAT-1];
  assign pixel_out = r_pixel_out;

endmodule

// File: tb/tb_conv3x3_filter.sv
// Directed bench for conv3x3_filter on an 8x6 image with 4-bit pixels.
module tb_conv3x3_filter;

  localparam int W = 8;
  localparam int H = 6;
  localparam int P = 4;

  localparam int E_RAMP_PASS  = 0;
  localparam int E_FIVE       = 1;
  localparam int E_ZERO       = 2;
  localparam int E_EDGE_SOB   = 3;
  localparam int E_EDGE_PASS  = 4;
  localparam int E_EDGE_GAUSS = 5;

  localparam int I_RAMP = 0;
  localparam int I_FLAT = 1;
  localparam int I_EDGE = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   mode;
  logic [P-1:0] thresh;
  logic         in_ready;
  logic [P-1:0] pixel_in;
  logic         out_ready;
  logic [P-1:0] pixel_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic         mon_en = 1'b0;
  logic [1:0]   sh;
  logic [P-1:0] got_q [$];

  always #5 clk = ~clk;

  conv3x3_filter #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .thresh    (thresh),
    .in_ready  (in_ready),
    .pixel_in  (pixel_in),
    .out_ready (out_ready),
    .pixel_out (pixel_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  // in_ready history, used to check the fixed two-cycle latency
  always @(posedge clk) begin
    if (rst) sh <= 2'b00;
    else     sh <= {sh[0], in_ready};
  end

  always @(negedge clk) begin
    if (mon_en) chk("latency", {31'd0, out_ready}, {31'd0, sh[1]});
    if (out_ready) got_q.push_back(pixel_out);
  end

  function automatic logic [P-1:0] img(input int kind, input int r, input int c);
    case (kind)
      I_RAMP:  return P'(c);
      I_FLAT:  return P'(5);
      default: return (c >= 4) ? P'(15) : P'(0);
    endcase
  endfunction

  function automatic logic [P-1:0] exp_val(input int e, input int r, input int c);
    if (r < 2 || c < 2) return '0;
    case (e)
      E_RAMP_PASS:  return P'(c - 1);
      E_FIVE:       return P'(5);
      E_ZERO:       return P'(0);
      E_EDGE_SOB:   return (c == 4 || c == 5) ? P'(15) : P'(0);
      E_EDGE_PASS:  return (c >= 5) ? P'(15) : P'(0);
      E_EDGE_GAUSS: return (c == 4) ? P'(3) : (c == 5) ? P'(11) : (c >= 6) ? P'(15) : P'(0);
      default:      return '0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input int kind, input logic [1:0] m0, input logic [1:0] m1, input int gap);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == 0 && c == 0) mode = m0;
        if (r == 3 && c == 0) mode = m1;
        in_ready = 1'b1;
        pixel_in = img(kind, r, c);
        step();
        in_ready = 1'b0;
        repeat (gap) step();
      end
    end
  endtask

  task automatic check_frame(input string name, input int e);
    logic [P-1:0] v;
    for (int i = 0; i < W * H; i++) begin
      if (got_q.size() > 0) begin
        v = got_q.pop_front();
        chk(name, {28'd0, v}, {28'd0, exp_val(e, i / W, i % W)});
      end
    end
    $display("[TB] frame %s checked", name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_ready = 1'b0; mode = 2'd0; thresh = '0; pixel_in = '0;
    repeat (3) step();
    chk("rst_out_ready", {31'd0, out_ready}, 32'd0);
    chk("rst_pixel_out", {28'd0, pixel_out}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    drive_frame(I_RAMP, 2'd0, 2'd0, 0);
    repeat (3) step();
    chk("ramp_count", got_q.size(), 48);
    check_frame("ramp_pass", E_RAMP_PASS);

    drive_frame(I_FLAT, 2'd1, 2'd1, 0);
    repeat (3) step();
    chk("flat_gauss_count", got_q.size(), 48);
    check_frame("flat_gauss", E_FIVE);

    drive_frame(I_FLAT, 2'd2, 2'd2, 0);
    repeat (3) step();
    check_frame("flat_sobel", E_ZERO);

    drive_frame(I_EDGE, 2'd2, 2'd2, 0);
    repeat (3) step();
    check_frame("edge_sobel", E_EDGE_SOB);

    thresh = 4'd8;
    drive_frame(I_EDGE, 2'd3, 2'd3, 0);
    repeat (3) step();
    check_frame("edge_thresh", E_EDGE_SOB);

    drive_frame(I_EDGE, 2'd1, 2'd1, 0);
    repeat (3) step();
    check_frame("edge_gauss", E_EDGE_GAUSS);

    drive_frame(I_EDGE, 2'd2, 2'd2, 2);
    repeat (3) step();
    chk("gapped_count", got_q.size(), 48);
    check_frame("edge_sobel_gapped", E_EDGE_SOB);

    // mode changes mid-frame; second frame follows the first back to back
    drive_frame(I_EDGE, 2'd0, 2'd2, 0);
    drive_frame(I_EDGE, 2'd2, 2'd2, 0);
    repeat (3) step();
    chk("modechg_count", got_q.size(), 96);
    check_frame("modechg_f1_pass", E_EDGE_PASS);
    check_frame("modechg_f2_sobel", E_EDGE_SOB);

    // partial ramp frame up to row 3 col 4, then reset in the row 3 col 5 slot
    mode = 2'd0;
    for (int i = 0; i < 3 * W + 5; i++) begin
      in_ready = 1'b1;
      pixel_in = img(I_RAMP, i / W, i % W);
      step();
    end
    in_ready = 1'b0;
    rst = 1'b1;
    step();
    chk("midrst_out_ready", {31'd0, out_ready}, 32'd0);
    chk("midrst_pixel_out", {28'd0, pixel_out}, 32'd0);
    rst = 1'b0;
    got_q.delete();
    drive_frame(I_RAMP, 2'd0, 2'd0, 0);
    repeat (3) step();
    chk("post_rst_count", got_q.size(), 48);
    check_frame("post_rst_ramp", E_RAMP_PASS);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
